// File: rtl/oracle_vector_sequencer_pkg.sv
// Shared types and default sizes for the oracle vector sequencer.
package oracle_seq_pkg;

  // Sequencer phases: shift a vector in, clock the DUT, let PO settle, shift the response out.
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    UNLOAD = 2'd3
  } seq_state_t;

  // Role of a shift-register instance: deserializer (SI -> PI) or serializer (PO -> SO).
  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } serdes_dir_t;

  // Default sizes match the s713 benchmark: 35 primary inputs, 23 primary outputs.
  localparam int NIN_DEF     = 35;
  localparam int NOUT_DEF    = 23;
  localparam int NSTEP_W_DEF = 4;

endpackage

// File: rtl/oracle_vector_sequencer_serdes_shift_reg.sv
// Right-shifting register used as the input deserializer or the output serializer.
// Bit 0 leaves first and new bits enter at the MSB. After WIDTH shifts, the first bit
// received is in bit 0.
module serdes_shift_reg
  import oracle_seq_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter serdes_dir_t DIR   = DIR_IN
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] word_next,
  output logic             ser_out
);

  logic [WIDTH-1:0] sr;
  logic             fill;

  // The serializer shifts in zeros. Only the deserializer takes in serial data.
  assign fill = (DIR == DIR_IN) ? ser_in : 1'b0;

  // Next register value. A parallel load wins over a shift.
  always_comb begin
    // NOTE: default assignment first so every path assigns word_next (no latch).
    word_next = sr;
    if (load_en) begin
      word_next = par_in;
    end else if (shift_en) begin
      word_next = {fill, sr[WIDTH-1:1]};
    end
  end

  // Shift register state with synchronous clear.
  always_ff @(posedge CK) begin
    // NOTE: non-blocking assignment for clocked state avoids races between flops.
    if (RST) sr <= '0;
    else     sr <= word_next;
  end

  assign ser_out = sr[0];

endmodule

// File: rtl/oracle_vector_sequencer.sv
// Oracle query engine. It deserializes an input vector onto PI and pulses DUT_CE for
// a programmed number of steps. It then captures PO and serializes the response on SO.
module oracle_vector_sequencer
  import oracle_seq_pkg::*;
#(
  parameter int NIN     = NIN_DEF,
  parameter int NOUT    = NOUT_DEF,
  parameter int NSTEP_W = NSTEP_W_DEF
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               SI,
  input  logic               SI_VALID,
  output logic               SI_READY,
  input  logic [NSTEP_W-1:0] NSTEP,
  output logic [NIN-1:0]     PI,
  output logic               DUT_CE,
  input  logic [NOUT-1:0]    PO,
  output logic               SO,
  output logic               SO_VALID,
  input  logic               SO_READY,
  output logic               BUSY
);

  localparam int BIT_W = $clog2(NIN);
  localparam int OUT_W = $clog2(NOUT);

  seq_state_t         state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [OUT_W-1:0]   out_cnt;
  logic [NSTEP_W-1:0] step_cnt;
  logic [NSTEP_W-1:0] step_reg;

  logic               si_beat;
  logic               so_beat;
  logic [NIN-1:0]     in_next;
  logic               unused_in_bit;
  logic [NOUT-1:0]    unused_out_word;

  assign si_beat = SI_VALID && SI_READY;
  assign so_beat = SO_VALID && SO_READY;

  // The deserializer's next value already contains the bit arriving on this beat.
  // On the final beat that value is the complete vector.
  serdes_shift_reg #(.WIDTH(NIN), .DIR(DIR_IN)) u_in_sr (
    .CK        (CK),
    .RST       (RST),
    .shift_en  (si_beat),
    .load_en   (1'b0),
    .ser_in    (SI),
    .par_in    ('0),
    .word_next (in_next),
    .ser_out   (unused_in_bit)
  );

  // The serializer captures PO on the edge that leaves SETTLE. It shifts on each SO beat.
  serdes_shift_reg #(.WIDTH(NOUT), .DIR(DIR_OUT)) u_out_sr (
    .CK        (CK),
    .RST       (RST),
    .shift_en  (so_beat),
    .load_en   (state == SETTLE),
    .ser_in    (1'b0),
    .par_in    (PO),
    .word_next (unused_out_word),
    .ser_out   (SO)
  );

  // BUSY is low only when no vector bits have been accepted yet.
  assign BUSY = !((state == LOAD) && (bit_cnt == '0));

  // Sequencer FSM with registered handshake, enable and PI outputs.
  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= LOAD;
      PI       <= '0;
      DUT_CE   <= 1'b0;
      SO_VALID <= 1'b0;
      SI_READY <= 1'b1;
      bit_cnt  <= '0;
      out_cnt  <= '0;
      step_cnt <= '0;
      step_reg <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (si_beat) begin
            // A zero step count still advances the DUT once.
            if (bit_cnt == '0) begin
              step_reg <= (NSTEP == '0) ? NSTEP_W'(1) : NSTEP;
            end
            if (bit_cnt == BIT_W'(NIN - 1)) begin
              PI       <= in_next;
              bit_cnt  <= '0;
              step_cnt <= '0;
              SI_READY <= 1'b0;
              DUT_CE   <= 1'b1;
              state    <= STEP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        STEP: begin
          if (step_cnt == step_reg - NSTEP_W'(1)) begin
            step_cnt <= '0;
            DUT_CE   <= 1'b0;
            state    <= SETTLE;
          end else begin
            step_cnt <= step_cnt + NSTEP_W'(1);
          end
        end
        SETTLE: begin
          SO_VALID <= 1'b1;
          state    <= UNLOAD;
        end
        UNLOAD: begin
          if (so_beat) begin
            if (out_cnt == OUT_W'(NOUT - 1)) begin
              out_cnt  <= '0;
              SO_VALID <= 1'b0;
              SI_READY <= 1'b1;
              state    <= LOAD;
            end else begin
              out_cnt <= out_cnt + OUT_W'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_oracle_vector_sequencer.sv
// Bench for oracle_vector_sequencer. The sequencer drives a clock-enabled stand-in for
// an s713-like sequential circuit. Each response is compared with the result of applying
// the circuit's next-state and output functions once per programmed step.
module tb_oracle_vector_sequencer;

  localparam int NIN     = 35;
  localparam int NOUT    = 23;
  localparam int NSTEP_W = 4;
  localparam int NFF     = 19;

  logic               CK = 1'b0;
  logic               RST = 1'b1;
  logic               SI = 1'b0;
  logic               SI_VALID = 1'b0;
  logic               SI_READY;
  logic [NSTEP_W-1:0] NSTEP = '0;
  logic [NIN-1:0]     PI;
  logic               DUT_CE;
  logic [NOUT-1:0]    PO;
  logic               SO;
  logic               SO_VALID;
  logic               SO_READY = 1'b1;
  logic               BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  oracle_vector_sequencer #(.NIN(NIN), .NOUT(NOUT), .NSTEP_W(NSTEP_W)) dut (
    .CK       (CK),
    .RST      (RST),
    .SI       (SI),
    .SI_VALID (SI_VALID),
    .SI_READY (SI_READY),
    .NSTEP    (NSTEP),
    .PI       (PI),
    .DUT_CE   (DUT_CE),
    .PO       (PO),
    .SO       (SO),
    .SO_VALID (SO_VALID),
    .SO_READY (SO_READY),
    .BUSY     (BUSY)
  );

  always #5 CK = ~CK;

  // Sequential benchmark behaviour: 19 flops, 35 inputs, 23 outputs.
  function automatic logic [NFF-1:0] ckt_next(input logic [NFF-1:0] s, input logic [NIN-1:0] v);
    return {s[17:0], s[18] ^ s[5]} ^ v[18:0] ^ {3'b000, v[34:19]};
  endfunction

  function automatic logic [NOUT-1:0] ckt_out(input logic [NFF-1:0] s, input logic [NIN-1:0] v);
    return {s, 4'b0000} ^ v[22:0] ^ {v[34:23], 11'b0} ^ {22'b0, ^s};
  endfunction

  // Clock-enabled circuit stand-in. It is reset only once, at the start of the run.
  logic           ckt_rst = 1'b1;
  logic [NFF-1:0] ckt_s;
  always @(posedge CK) begin
    if (ckt_rst)     ckt_s <= '0;
    else if (DUT_CE) ckt_s <= ckt_next(ckt_s, PI);
  end
  assign PO = ckt_out(ckt_s, PI);

  // Edge counter, DUT_CE pulse counter and PI-stability monitor during steps.
  int             cyc = 0;
  int             ce_count = 0;
  int             pi_unstable = 0;
  logic [NIN-1:0] pi_step = '0;
  always @(posedge CK) begin
    cyc <= cyc + 1;
    if (DUT_CE) begin
      ce_count <= ce_count + 1;
      if (PI !== pi_step) pi_unstable <= pi_unstable + 1;
    end
  end

  // Reference: circuit state after each whole vector, and the expected response.
  logic [NFF-1:0]  ref_s = '0;
  logic [NOUT-1:0] exp_resp = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Shift one vector in, LSB first, optionally idling SI_VALID before every bit.
  task automatic send_vector(input logic [NIN-1:0] vec, input logic [NSTEP_W-1:0] nstep,
                             input bit gap, output int cycles);
    int             start;
    int             bad;
    int             w;
    int             nsteps;
    logic [NIN-1:0] prev;
    start  = cyc;
    bad    = 0;
    prev   = PI;
    nsteps = (nstep == '0) ? 1 : int'(nstep);
    for (int i = 0; i < NIN; i++) begin
      if (gap) begin
        SI_VALID = 1'b0;
        tick();
        if (PI !== prev) bad++;
      end
      SI       = vec[i];
      SI_VALID = 1'b1;
      NSTEP    = (i == 0) ? nstep : NSTEP_W'($urandom_range(15));
      w = 0;
      while (!SI_READY && w < 100) begin
        tick();
        w++;
      end
      if (w == 100) check("si_ready_timeout", 64'd0, 64'd1);
      if (PI !== prev) bad++;
      tick();
    end
    SI_VALID = 1'b0;
    cycles   = cyc - start;
    check("pi_hold_mid_shift", 64'(bad), 64'd0);
    check("pi_after_load", 64'(PI), 64'(vec));
    pi_step = vec;
    for (int k = 0; k < nsteps; k++) ref_s = ckt_next(ref_s, vec);
    exp_resp = ckt_out(ref_s, vec);
  endtask

  // Collect one response, optionally holding SO_READY low after 5 bits.
  task automatic recv_resp(input int hold, output logic [NOUT-1:0] got, output int cycles);
    int   start;
    int   n;
    int   guard;
    int   bad;
    int   ce0;
    bit   held;
    logic snap;
    start = cyc;
    n     = 0;
    guard = 0;
    held  = 1'b0;
    got   = '0;
    while (n < NOUT && guard < 400) begin
      if (hold > 0 && n == 5 && !held) begin
        held     = 1'b1;
        SO_READY = 1'b0;
        snap     = SO;
        bad      = 0;
        ce0      = ce_count;
        repeat (hold) begin
          tick();
          if (SO !== snap || SO_VALID !== 1'b1 || DUT_CE !== 1'b0) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        check("hold_no_ce", 64'(ce_count - ce0), 64'd0);
        SO_READY = 1'b1;
      end
      if (SO_VALID) begin
        got[n] = SO;
        n++;
      end
      tick();
      guard++;
    end
    if (guard == 400) check("so_timeout", 64'(n), 64'(NOUT));
    cycles = cyc - start;
    check("back_to_load", {61'd0, SO_VALID, SI_READY, BUSY}, {61'd0, 3'b010});
  endtask

  initial begin
    int              lc;
    int              rc;
    int              ce0;
    int              w;
    int              gold_bad;
    logic [NIN-1:0]  v;
    logic [NOUT-1:0] got;

    repeat (3) tick();
    RST     = 1'b0;
    ckt_rst = 1'b0;
    check("reset_state", {57'd0, SO_VALID, SI_READY, BUSY, DUT_CE, SO, 2'b00},
          {57'd0, 7'b0100000});
    check("reset_pi", 64'(PI), 64'd0);

    // Reset in the middle of UNLOAD.
    send_vector({$urandom, 3'($urandom)}, 4'd1, 1'b0, lc);
    w = 0;
    while (!SO_VALID && w < 20) begin
      tick();
      w++;
    end
    check("unload_reached", 64'(SO_VALID), 64'd1);
    repeat (3) tick();
    check("busy_in_unload", 64'(BUSY), 64'd1);
    ce0 = ce_count;
    RST = 1'b1;
    tick();
    check("mid_reset_state", {60'd0, SO_VALID, SI_READY, BUSY, DUT_CE}, {60'd0, 4'b0100});
    check("mid_reset_pi", 64'(PI), 64'd0);
    repeat (2) tick();
    RST = 1'b0;
    check("reset_no_ce", 64'(ce_count - ce0), 64'd0);

    // Single step with continuous handshakes.
    ce0 = ce_count;
    send_vector(35'h5_5555_5555, 4'd1, 1'b0, lc);
    recv_resp(0, got, rc);
    check("load_cycles", 64'(lc), 64'(NIN));
    check("total_cycles", 64'(lc + rc), 64'(NIN + NOUT + 2));
    check("ce_one", 64'(ce_count - ce0), 64'd1);
    check("resp_5555", 64'(got), 64'(exp_resp));

    // A zero step count acts as one step. Then five steps.
    ce0 = ce_count;
    send_vector({$urandom, 3'($urandom)}, 4'd0, 1'b0, lc);
    recv_resp(0, got, rc);
    check("ce_nstep0", 64'(ce_count - ce0), 64'd1);
    check("resp_nstep0", 64'(got), 64'(exp_resp));
    ce0 = ce_count;
    send_vector({$urandom, 3'($urandom)}, 4'd5, 1'b0, lc);
    recv_resp(0, got, rc);
    check("ce_nstep5", 64'(ce_count - ce0), 64'd5);
    check("resp_nstep5", 64'(got), 64'(exp_resp));
    check("pi_stable_step", 64'(pi_unstable), 64'd0);

    // SI_VALID alternates 0/1 during the load.
    send_vector({$urandom, 3'($urandom)}, 4'd2, 1'b1, lc);
    recv_resp(0, got, rc);
    check("gap_load_cycles", 64'(lc), 64'(2 * NIN));
    check("resp_gap", 64'(got), 64'(exp_resp));

    // Consumer stalls for 20 cycles in UNLOAD.
    send_vector({$urandom, 3'($urandom)}, 4'd3, 1'b0, lc);
    recv_resp(20, got, rc);
    check("resp_hold", 64'(got), 64'(exp_resp));

    // 100 random vectors; circuit state carries over from one vector to the next.
    gold_bad = 0;
    for (int i = 0; i < 100; i++) begin
      v = {$urandom, 3'($urandom)};
      send_vector(v, 4'd1, 1'b0, lc);
      recv_resp(0, got, rc);
      check($sformatf("golden_%0d", i), 64'(got), 64'(exp_resp));
    end
    check("golden_final_state", 64'(ckt_s), 64'(ref_s));
    check("pi_stable_all", 64'(pi_unstable), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1);
  end

endmodule
